// File: rtl/cla_seq_pkg.sv
// Shared definitions for the CLA word sequencer.
//   - state_e    : sequencer FSM states (IDLE, RUN, DONE)
//   - DEF_SLICE_W / DEF_NUM_SLICES : default geometry (8-bit slice, 4 slices)
//   - idx_w()    : width of the slice index counter (clog2, minimum 1)
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_SLICE_W    = 8;
  localparam int DEF_NUM_SLICES = 4;

  // Slice index width; a single-slice word still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/cla_word_sequencer_slice.sv
// cla_slice: SLICE_W-bit combinational carry-lookahead adder slice.
// Ports:
//   a, b  [SLICE_W-1:0] in  : slice operands
//   cin               in  : slice carry-in
//   sum   [SLICE_W-1:0] out : slice sum
//   cout  [SLICE_W-1:0] out : carry out of every bit (cout[i] = carry into bit i+1)
module cla_slice
  import cla_seq_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic [SLICE_W-1:0] cout
);

  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W-1:0] g_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Lookahead carries: c[i] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, flattened per bit.
  always_comb begin : carry_chain
    logic acc_s;
    logic prop_s;
    cout = {SLICE_W{1'b0}};
    for (int i = 0; i < SLICE_W; i++) begin
      acc_s  = g_s[i];
      prop_s = p_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc_s  = acc_s | (prop_s & g_s[j]);
        prop_s = prop_s & p_s[j];
      end
      cout[i] = acc_s | (prop_s & cin);
    end
  end

  // Sum bit i uses the carry into bit i (cin for bit 0).
  always_comb begin
    sum = {SLICE_W{1'b0}};
    for (int i = 0; i < SLICE_W; i++) begin
      if (i == 0) begin
        sum[i] = p_s[i] ^ cin;
      end else begin
        sum[i] = p_s[i] ^ cout[i-1];
      end
    end
  end

endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds (or subtracts) two W-bit words by stepping one shared
// SLICE_W-bit CLA slice across NUM_SLICES slices, carrying between cycles.
// Optional feature macro: CLA_SEQ_SUB_EN (subtraction via sub port); when undefined
// the sub port is ignored and no operand inversion is built.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   A, B, Cin, sub      : operands, sampled at accept
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   Sum, Cout, Ovf      : registered result, carry out of MSB, signed overflow
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] A,
  input  logic [SLICE_W*NUM_SLICES-1:0] B,
  input  logic                          Cin,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] Sum,
  output logic                          Cout,
  output logic                          Ovf
);

  localparam int W  = SLICE_W * NUM_SLICES;
  localparam int IW = idx_w(NUM_SLICES);
  localparam logic [IW-1:0] K_LAST = IW'(NUM_SLICES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   k_q, k_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_sl_s;
  logic [SLICE_W-1:0] b_sl_s;
  logic [SLICE_W-1:0] slice_sum_s;
  logic [SLICE_W-1:0] slice_cout_s;
  logic               unused_cout_s;

  assign a_sl_s = a_q[k_q*SLICE_W +: SLICE_W];
  assign b_sl_s = b_q[k_q*SLICE_W +: SLICE_W];

  cla_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_sl_s),
    .b    (b_sl_s),
    .cin  (carry_q),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Only the top two per-bit carries feed the sequencer; the rest are informational.
  assign unused_cout_s = ^slice_cout_s;

`ifndef CLA_SEQ_SUB_EN
  logic unused_sub_s;
  assign unused_sub_s = sub;
`endif

  // Next-state, operand capture and per-slice result update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = A;
`ifdef CLA_SEQ_SUB_EN
          // A - B computed as A + ~B + 1; Cin is ignored for subtraction.
          if (sub) begin
            b_d     = ~B;
            carry_d = 1'b1;
          end else begin
            b_d     = B;
            carry_d = Cin;
          end
`else
          b_d     = B;
          carry_d = Cin;
`endif
          k_d     = {IW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = slice_sum_s;
        carry_d = slice_cout_s[SLICE_W-1];
        if (k_q == K_LAST) begin
          cout_d  = slice_cout_s[SLICE_W-1];
          ovf_d   = slice_cout_s[SLICE_W-1] ^ slice_cout_s[SLICE_W-2];
          k_d     = {IW{1'b0}};
          state_d = DONE;
        end else begin
          k_d     = k_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      carry_q <= 1'b0;
      k_q     <= {IW{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer with a result scoreboard (default geometry).
module tb_cla_word_sequencer;

  localparam int SW = 8;
  localparam int NS = 4;
  localparam int W  = SW * NS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic         Cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] Sum;
  logic         Cout, Ovf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cla_word_sequencer #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic at W+1 bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t         e;
    logic [W-1:0] bx;
    logic         ci;
    logic [W:0]   full;
    bx = b;
    ci = c;
`ifdef CLA_SEQ_SUB_EN
    if (s) begin
      bx = ~b;
      ci = 1'b1;
    end
`endif
    full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input int hold, input bit glitch);
    exp_t e;
    int   cyc;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    q.push_back(model(a, b, c, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (glitch) begin
      check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
      in_valid = 1'b1; A = 32'h1234_5678; B = 32'h0F0F_0F0F; Cin = 1'b1; sub = ~s;
    end
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      in_valid = 1'b0;
    end while (!out_valid && cyc < 50);
    check({tag, "_latency"}, 64'(cyc), 64'(NS));
    if (q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'(q.size()));
      e = '0;
    end else begin
      e = q.pop_front();
    end
    check({tag, "_sum"},  64'(Sum),  64'(e.sum));
    check({tag, "_cout"}, 64'(Cout), 64'(e.cout));
    check({tag, "_ovf"},  64'(Ovf),  64'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_sum"}, 64'({Sum, Cout, Ovf}), 64'({e.sum, e.cout, e.ovf}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rel_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'({Sum, Cout, Ovf}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    check("const_add_ff_1", 64'(Sum), 64'h0000_0100);
    run_op("carry_all",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
    check("const_carry_all", 64'({Sum, Cout}), 64'({32'h0000_0000, 1'b1}));
    run_op("ovf_pos",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    check("const_ovf_pos", 64'({Sum, Ovf}), 64'({32'h8000_0000, 1'b1}));
    run_op("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0);
`ifdef CLA_SEQ_SUB_EN
    check("const_sub_5_7", 64'({Sum, Cout, Ovf}), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
`else
    check("const_sub_5_7", 64'(Sum), 64'h0000_000C);
`endif
    run_op("bp_glitch",  32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0, 3, 1'b1);
    // Accept immediately after the release edge.
    run_op("back2back",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op("rand",       32'($urandom), 32'($urandom), 1'b0, 1'b0, 1, 1'b0);

    // Reset after two RUN cycles discards the operation.
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    q.push_back(model(A, B, Cin, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    e = q.pop_back();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum",       64'(Sum),       64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0, 1'b0);
    check("const_after_rst", 64'(Sum), 64'd7);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
